ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory port, presents one fetched
//  instruction plus its PC+4 to the IF/ID decode register, and applies branch/jump/jr redirects from
//  decode. Feeds the IF/ID register (i_ins) directly; one request outstanding at most.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; first fetch address
// PORTS
//  clk              in   1   single clock, rising edge
//  rst_n            in   1   reset, asynchronous, active-low
//  o_imem_req       out  1   fetch request; held high until i_imem_ack
//  o_imem_addr      out  32  fetch address, word aligned, stable while o_imem_req=1
//  i_imem_ack       in   1   memory accepts/returns; i_imem_rdata valid this cycle
//  i_imem_rdata     in   32  instruction word
//  o_ins            out  32  fetched instruction to IF/ID
//  o_pc4            out  32  address of o_ins + 4
//  o_valid          out  1   o_ins/o_pc4 hold an unconsumed instruction
//  i_stall          in   1   decode not accepting; o_valid && !i_stall = consume
//  i_redirect       in   2   00 none, 01 branch, 10 jump, 11 jr (one-cycle pulse)
//  i_id_pc4         in   32  PC+4 of the redirecting instruction
//  i_imm16          in   16  branch offset (words, signed)
//  i_imm26          in   26  jump index
//  i_jr_addr        in   32  register target for jr
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, o_imem_addr=RESET_PC, o_imem_req=0, o_valid=0, o_ins=0,
//   o_pc4=0, state=READY. Reset mid-request abandons it; a late ack after reset is ignored.
//  Targets (mod 2^32): branch = i_id_pc4 + {{14{imm16[15]}},imm16,2'b00};
//   jump = {i_id_pc4[31:28],imm26,2'b00}; jr = {i_jr_addr[31:2],2'b00}.
//  FSM states READY, FETCH, DROP; all outputs registered.
//   READY: redirect -> pc<=target, stay READY (issue next cycle). Else if !o_valid || !i_stall:
//    o_imem_req<=1, o_imem_addr<=pc, ->FETCH. Else hold.
//   FETCH: ack && no redirect -> o_ins<=rdata, o_pc4<=o_imem_addr+4, o_valid<=1, pc<=o_imem_addr+4,
//    req<=0, ->READY. ack && redirect -> discard data, pc<=target, req<=0, ->READY.
//    !ack && redirect -> pc<=target, req/addr held, ->DROP. Else hold.
//   DROP: ack -> discard, req<=0, ->READY. Further redirect -> pc<=newest target.
//  o_valid: set by capture; cleared on consume (o_valid && !i_stall) or any redirect (squash, even if
//   stalled). Capture wins over same-cycle consume of prior word (cannot overlap: issue requires slot free).
//  No delay slot: instruction in o_ins at redirect is squashed.
//  Latency: req asserted 1 cycle after READY decision; o_valid 1 cycle after ack. Peak 1 instr / 2 cycles.
//  i_redirect ignored when 00; i_stall has no effect on redirects or outstanding request.
// STRUCTURE
//  Shared package: redirect encodings (RD_NONE/RD_BR/RD_J/RD_JR), state encodings, RESET_PC default.
//  One sub-module: pc_target (combinational target mux from i_redirect, i_id_pc4, i_imm16, i_imm26,
//  i_jr_addr). FSM, PC and output registers stay in ifetch.
// TESTING
//  1 Reset release, ack same cycle as req, no stall -> addrs 0,4,8 on successive reqs; o_ins matches
//    rdata, o_pc4 = 4,8,12; one instruction every 2 cycles.
//  2 Stall: o_valid=1, i_stall=1 for 5 cycles -> o_ins stable, no new req; stall drop -> next req addr+4.
//  3 Branch: i_id_pc4=0x100, imm16=0xFFFE, redirect=01 -> o_valid cleared, next req addr 0xF8;
//    jump imm26=0x0000040 from pc4 0x1000_0000 -> addr 0x1000_0100; jr 0x2003 -> 0x2000.
//  4 Redirect while req pending, ack 3 cycles later -> rdata discarded (o_valid stays 0), req held at old
//    addr until ack, then new req at target.
//  5 Redirect same cycle as ack -> data discarded, next req at target; redirect + stall -> squash anyway.
//  6 rst_n low mid-FETCH -> outputs to reset values immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module : ifetch_pkg
// Brief  : Shared encodings and defaults for the instruction-fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [1:0] redirect_t;

    localparam redirect_t RD_NONE = 2'b00;
    localparam redirect_t RD_BR   = 2'b01;
    localparam redirect_t RD_J    = 2'b10;
    localparam redirect_t RD_JR   = 2'b11;

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_if.sv
// ============================================================================
// Module : ifetch_if
// Brief  : Instruction-memory req/ack port between fetch stage and memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ifetch_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_ack,
        input  i_imem_rdata
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_ack,
        output i_imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/ifetch_pc_target.sv
// ============================================================================
// Module : pc_target
// Brief  : Combinational redirect target mux (branch / jump / jr).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_target
    import ifetch_pkg::*;
(
    input  wire redirect_t   redirect,
    input  wire logic [31:0] id_pc4,
    input  wire logic [15:0] imm16,
    input  wire logic [25:0] imm26,
    input  wire logic [31:0] jr_addr,
    output logic      [31:0] target
);

    always_comb begin
        target = id_pc4;
        case (redirect)
            RD_BR:   target = id_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
            RD_J:    target = {id_pc4[31:28], imm26, 2'b00};
            RD_JR:   target = word_align(jr_addr);
            default: target = id_pc4;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
// Module : ifetch
// Brief  : Fetch stage: PC, single-outstanding imem request, IF/ID output reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire              clk,
    input  wire              rst_n,
    ifetch_if.master         imem,
    output logic      [31:0] o_ins,
    output logic      [31:0] o_pc4,
    output logic             o_valid,
    input  wire              i_stall,
    input  wire redirect_t   i_redirect,
    input  wire logic [31:0] i_id_pc4,
    input  wire logic [15:0] i_imm16,
    input  wire logic [25:0] i_imm26,
    input  wire logic [31:0] i_jr_addr
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] w_target;
    logic        w_redir;
    logic        w_consume;

    assign w_redir   = (i_redirect != RD_NONE);
    assign w_consume = o_valid && !i_stall;

    pc_target u_pc_target (
        .redirect (i_redirect),
        .id_pc4   (i_id_pc4),
        .imm16    (i_imm16),
        .imm26    (i_imm26),
        .jr_addr  (i_jr_addr),
        .target   (w_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_READY;
            r_pc             <= RESET_PC;
            imem.o_imem_req  <= 1'b0;
            imem.o_imem_addr <= RESET_PC;
            o_ins            <= 32'h0;
            o_pc4            <= 32'h0;
            o_valid          <= 1'b0;
        end else begin
            if (w_consume) begin
                o_valid <= 1'b0;
            end
            case (r_state)
                ST_READY: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                    end else if (!o_valid || !i_stall) begin
                        imem.o_imem_req  <= 1'b1;
                        imem.o_imem_addr <= r_pc;
                        r_state          <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem.i_imem_ack) begin
                        imem.o_imem_req <= 1'b0;
                        r_state         <= ST_READY;
                        if (w_redir) begin
                            r_pc <= w_target;
                        end else begin
                            o_ins   <= imem.i_imem_rdata;
                            o_pc4   <= imem.o_imem_addr + 32'd4;
                            o_valid <= 1'b1;
                            r_pc    <= imem.o_imem_addr + 32'd4;
                        end
                    end else if (w_redir) begin
                        // Request must complete at its original address; its data is dropped.
                        r_pc    <= w_target;
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                    end
                    if (imem.i_imem_ack) begin
                        imem.o_imem_req <= 1'b0;
                        r_state         <= ST_READY;
                    end
                end
                default: r_state <= ST_READY;
            endcase
            // No delay slot: any redirect squashes the held instruction, stalled or not.
            if (w_redir) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module : tb_ifetch
// Brief  : Directed self-checking bench for the ifetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch;
    import ifetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    redirect_t   redirect;
    logic [31:0] id_pc4;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_addr;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        valid;
    logic        auto_ack;
    logic        man_ack;

    int n_checks;
    int n_pass;

    ifetch_if imem_if ();

    // Memory returns a recognisable word: upper half C0DE, lower half = address.
    assign imem_if.i_imem_ack   = auto_ack ? imem_if.o_imem_req : man_ack;
    assign imem_if.i_imem_rdata = {16'hC0DE, imem_if.o_imem_addr[15:0]};

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (imem_if.master),
        .o_ins      (ins),
        .o_pc4      (pc4),
        .o_valid    (valid),
        .i_stall    (stall),
        .i_redirect (redirect),
        .i_id_pc4   (id_pc4),
        .i_imm16    (imm16),
        .i_imm26    (imm26),
        .i_jr_addr  (jr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, ".req"}, {31'h0, imem_if.o_imem_req}, {31'h0, req});
        if (req) begin
            check({tag, ".addr"}, imem_if.o_imem_addr, addr);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p);
        check({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
        if (v) begin
            check({tag, ".ins"}, ins, i);
            check({tag, ".pc4"}, pc4, p);
        end
    endtask

    task automatic do_redirect(input redirect_t kind);
        redirect = kind;
        step();
        redirect = RD_NONE;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = RD_NONE;
        id_pc4   = 32'h0;
        imm16    = 16'h0;
        imm26    = 26'h0;
        jr_addr  = 32'h0;
        auto_ack = 1'b1;
        man_ack  = 1'b0;

        // Reset state
        step();
        step();
        check("rst.req",   {31'h0, imem_if.o_imem_req}, 32'h0);
        check("rst.addr",  imem_if.o_imem_addr, 32'h0);
        check("rst.valid", {31'h0, valid}, 32'h0);
        check("rst.ins",   ins, 32'h0);
        check("rst.pc4",   pc4, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch, ack same cycle as req: one instruction every 2 cycles
        step(); check_req("seq0", 1'b1, 32'h0);
        step(); check_out("seq0", 1'b1, 32'hC0DE_0000, 32'h4);
                check_req("seq0i", 1'b0, 32'h0);
        step(); check_req("seq1", 1'b1, 32'h4);
                check_out("seq1c", 1'b0, 32'h0, 32'h0);
        step(); check_out("seq1", 1'b1, 32'hC0DE_0004, 32'h8);
        step(); check_req("seq2", 1'b1, 32'h8);
        step(); check_out("seq2", 1'b1, 32'hC0DE_0008, 32'hC);

        // Stall holds the word and blocks new requests
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_req("stall", 1'b0, 32'h0);
            check_out("stall", 1'b1, 32'hC0DE_0008, 32'hC);
        end
        stall = 1'b0;
        step(); check_req("unstall", 1'b1, 32'hC);
        step(); check_out("unstall", 1'b1, 32'hC0DE_000C, 32'h10);

        // Branch backwards while stalled: squash, then fetch 0x100 - 8
        stall  = 1'b1;
        id_pc4 = 32'h0000_0100;
        imm16  = 16'hFFFE;
        do_redirect(RD_BR);
        stall = 1'b0;
        check_out("br.squash", 1'b0, 32'h0, 32'h0);
        check_req("br.idle", 1'b0, 32'h0);
        step(); check_req("br", 1'b1, 32'h0000_00F8);
        step(); check_out("br", 1'b1, 32'hC0DE_00F8, 32'h0000_00FC);

        // Jump
        id_pc4 = 32'h1000_0000;
        imm26  = 26'h0000040;
        do_redirect(RD_J);
        check_out("j.squash", 1'b0, 32'h0, 32'h0);
        step(); check_req("j", 1'b1, 32'h1000_0100);
        step(); check_out("j", 1'b1, 32'hC0DE_0100, 32'h1000_0104);

        // Jump register with unaligned source
        jr_addr = 32'h0000_2003;
        do_redirect(RD_JR);
        step(); check_req("jr", 1'b1, 32'h0000_2000);
        step(); check_out("jr", 1'b1, 32'hC0DE_2000, 32'h0000_2004);

        // Redirect while request pending; ack arrives later
        auto_ack = 1'b0;
        step(); check_req("drop.iss", 1'b1, 32'h0000_2004);
        id_pc4 = 32'h0000_0400;
        imm16  = 16'h0010;
        do_redirect(RD_BR);
        check_req("drop.h1", 1'b1, 32'h0000_2004);
        check_out("drop.h1", 1'b0, 32'h0, 32'h0);
        step(); check_req("drop.h2", 1'b1, 32'h0000_2004);
        step(); check_req("drop.h3", 1'b1, 32'h0000_2004);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check_req("drop.done", 1'b0, 32'h0);
        check_out("drop.disc", 1'b0, 32'h0, 32'h0);
        step(); check_req("drop.new", 1'b1, 32'h0000_0440);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check_out("drop.new", 1'b1, 32'hC0DE_0440, 32'h0000_0444);

        // Redirect in the same cycle as ack
        auto_ack = 1'b1;
        step(); check_req("ackr.iss", 1'b1, 32'h0000_0444);
        id_pc4 = 32'h2000_0000;
        imm26  = 26'h0000008;
        do_redirect(RD_J);
        check_out("ackr.disc", 1'b0, 32'h0, 32'h0);
        step(); check_req("ackr", 1'b1, 32'h2000_0020);
        step(); check_out("ackr", 1'b1, 32'hC0DE_0020, 32'h2000_0024);

        // Redirect with stall still squashes
        stall   = 1'b1;
        jr_addr = 32'h0000_3000;
        do_redirect(RD_JR);
        stall = 1'b0;
        check_out("jrst.squash", 1'b0, 32'h0, 32'h0);
        step(); check_req("jrst", 1'b1, 32'h0000_3000);
        step(); check_out("jrst", 1'b1, 32'hC0DE_3000, 32'h0000_3004);

        // Asynchronous reset mid-FETCH; a late ack must be ignored
        auto_ack = 1'b0;
        step(); check_req("rst2.iss", 1'b1, 32'h0000_3004);
        #1 rst_n = 1'b0;
        #1;
        check("rst2.req",   {31'h0, imem_if.o_imem_req}, 32'h0);
        check("rst2.addr",  imem_if.o_imem_addr, 32'h0);
        check("rst2.valid", {31'h0, valid}, 32'h0);
        check("rst2.ins",   ins, 32'h0);
        check("rst2.pc4",   pc4, 32'h0);
        man_ack = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        man_ack = 1'b0;
        check_out("rst2.late", 1'b0, 32'h0, 32'h0);
        check_req("rst2.refetch", 1'b1, 32'h0);
        auto_ack = 1'b1;
        step(); check_out("rst2.fetch", 1'b1, 32'hC0DE_0000, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
